// File: rtl/types_pkg.sv
// Shared reservation-station types: payload struct, tag width, table depth.
package types_pkg;

  localparam int unsigned PTAG_W     = 6;
  localparam int unsigned RS_ENTRIES = 8;
  localparam int unsigned RS_IDX_W   = $clog2(RS_ENTRIES);

  typedef struct packed {
    logic [7:0]        op;
    logic [PTAG_W-1:0] dst_tag;
    logic [PTAG_W-1:0] src1_tag;
    logic              src1_rdy;
    logic [PTAG_W-1:0] src2_tag;
    logic              src2_rdy;
  } rs_data;

  // Marks each source whose tag matches a valid completion broadcast as ready.
  function automatic rs_data rs_wake(rs_data d, logic vld, logic [PTAG_W-1:0] tag);
    rs_data r;
    r = d;
    if (vld && (d.src1_tag == tag)) r.src1_rdy = 1'b1;
    if (vld && (d.src2_tag == tag)) r.src2_rdy = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rs_issue_ctrl_if.sv
// Dispatch, wakeup and issue signals of the reservation station.
interface rs_issue_ctrl_if;
  import types_pkg::*;

  logic [1:0]        disp_valid;
  rs_data            disp_entry [2];
  logic              disp_ready;
  logic              cdb_valid;
  logic [PTAG_W-1:0] cdb_tag;
  logic              issue_valid;
  rs_data            issue_entry;
  logic              issue_ready;
  logic [3:0]        free_count;

  modport master (
    output disp_valid, disp_entry, cdb_valid, cdb_tag, issue_ready,
    input  disp_ready, issue_valid, issue_entry, free_count
  );

  modport slave (
    input  disp_valid, disp_entry, cdb_valid, cdb_tag, issue_ready,
    output disp_ready, issue_valid, issue_entry, free_count
  );

endinterface

// File: rtl/rs_free_slot.sv
// Finds the two lowest set bits of a free mask and counts the set bits.
module rs_free_slot
  import types_pkg::*;
#(
  parameter int unsigned Entries = RS_ENTRIES
) (
  input  logic [Entries-1:0]             free,
  output logic [$clog2(Entries)-1:0]     idx0,
  output logic                           idx0_vld,
  output logic [$clog2(Entries)-1:0]     idx1,
  output logic                           idx1_vld,
  output logic [$clog2(Entries+1)-1:0]   count
);

  localparam int unsigned IdxW = $clog2(Entries);
  localparam int unsigned CntW = $clog2(Entries + 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  always_comb begin
    idx0     = '0;
    idx1     = '0;
    idx0_vld = 1'b0;
    idx1_vld = 1'b0;
    count    = '0;
    for (int i = 0; i < Entries; i++) begin
      if (free[i]) begin
        count = count + CntOne;
        if (!idx0_vld) begin
          idx0     = i[IdxW-1:0];
          idx0_vld = 1'b1;
        end else if (!idx1_vld) begin
          idx1     = i[IdxW-1:0];
          idx1_vld = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rs_issue_ctrl.sv
// 8-entry reservation station: 2-wide dispatch, CDB wakeup, oldest-ready issue.
// Define RS_STALL_CNT_EN to add the saturating dispatch-stall counter output.
module rs_issue_ctrl
  import types_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  rs_issue_ctrl_if.slave         bus
`ifdef RS_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  logic [RS_ENTRIES-1:0] valid_q, valid_d;
  rs_data                entry_q [RS_ENTRIES];
  rs_data                entry_d [RS_ENTRIES];
  // age_q[i][j] set: entry i is older than entry j.
  logic [RS_ENTRIES-1:0] age_q [RS_ENTRIES];
  logic [RS_ENTRIES-1:0] age_d [RS_ENTRIES];
  logic                  lock_q, lock_d;
  logic [RS_IDX_W-1:0]   lock_idx_q, lock_idx_d;

  logic [RS_IDX_W-1:0]   free_idx0, free_idx1;
  logic                  free_vld0, free_vld1;
  logic [3:0]            free_cnt;
  logic                  disp_ready;
  logic                  do_disp0, do_disp1;
  logic [RS_ENTRIES-1:0] rdy;
  logic [RS_IDX_W-1:0]   old_idx, sel_idx;
  logic                  blocked;
  logic                  issue_valid, fire;

  rs_free_slot #(
    .Entries (RS_ENTRIES)
  ) u_free_slot (
    .free     (~valid_q),
    .idx0     (free_idx0),
    .idx0_vld (free_vld0),
    .idx1     (free_idx1),
    .idx1_vld (free_vld1),
    .count    (free_cnt)
  );

  assign disp_ready = (free_cnt >= 4'd2);
  assign do_disp0   = bus.disp_valid[0] && disp_ready && free_vld0;
  assign do_disp1   = bus.disp_valid[1] && disp_ready && free_vld1;

  always_comb begin
    for (int i = 0; i < RS_ENTRIES; i++) begin
      rdy[i] = valid_q[i] && entry_q[i].src1_rdy && entry_q[i].src2_rdy;
    end
  end

  // Oldest ready entry: ready with no other ready entry older than it.
  always_comb begin
    old_idx = '0;
    blocked = 1'b0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < RS_ENTRIES; j++) begin
        if ((j != i) && rdy[j] && age_q[j][i]) blocked = 1'b1;
      end
      if (rdy[i] && !blocked) old_idx = i[RS_IDX_W-1:0];
    end
  end

  // A presented-but-stalled selection stays put even if an older entry wakes.
  assign sel_idx     = lock_q ? lock_idx_q : old_idx;
  assign issue_valid = !flush && (|rdy);
  assign fire        = issue_valid && bus.issue_ready;

  assign bus.disp_ready  = disp_ready;
  assign bus.free_count  = free_cnt;
  assign bus.issue_valid = issue_valid;
  assign bus.issue_entry = entry_q[sel_idx];

  always_comb begin
    valid_d    = valid_q;
    entry_d    = entry_q;
    age_d      = age_q;
    lock_d     = issue_valid && !bus.issue_ready;
    lock_idx_d = sel_idx;

    if (fire) valid_d[sel_idx] = 1'b0;

    for (int i = 0; i < RS_ENTRIES; i++) begin
      entry_d[i] = rs_wake(entry_q[i], bus.cdb_valid, bus.cdb_tag);
    end

    // New entry: younger than every slot (row cleared, column set).
    if (do_disp0) begin
      valid_d[free_idx0] = 1'b1;
      entry_d[free_idx0] = rs_wake(bus.disp_entry[0], bus.cdb_valid, bus.cdb_tag);
      age_d[free_idx0]   = '0;
      for (int j = 0; j < RS_ENTRIES; j++) age_d[j][free_idx0] = 1'b1;
    end
    if (do_disp1) begin
      valid_d[free_idx1] = 1'b1;
      entry_d[free_idx1] = rs_wake(bus.disp_entry[1], bus.cdb_valid, bus.cdb_tag);
      age_d[free_idx1]   = '0;
      for (int j = 0; j < RS_ENTRIES; j++) age_d[j][free_idx1] = 1'b1;
    end

    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      for (int i = 0; i < RS_ENTRIES; i++) age_q[i] <= '0;
    end else begin
      valid_q    <= valid_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      age_q      <= age_d;
    end
  end

  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

`ifdef RS_STALL_CNT_EN
  localparam logic [STALL_CNT_W-1:0] StallOne = STALL_CNT_W'(1);
  logic [STALL_CNT_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if ((|bus.disp_valid) && !disp_ready && (stall_q != '1)) begin
      stall_q <= stall_q + StallOne;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_rs_issue_ctrl.sv
// Random and directed bench for rs_issue_ctrl against an age-ordered queue model.
module tb_rs_issue_ctrl;
  import types_pkg::*;

  logic clk = 1'b0;
  logic reset, flush;
  always #5 clk = ~clk;

  rs_issue_ctrl_if bus ();

`ifdef RS_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  rs_issue_ctrl #(
    .STALL_CNT_W (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus)
`ifdef RS_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    rs_data d;
    int     id;
  } m_ent_t;

  m_ent_t mq[$];         // occupied entries, oldest first
  int     m_lock_id = -1;
  int     m_next_id = 0;
  int     m_stall   = 0;
  bit     m_known   = 0;
  int     tests     = 0;
  int     fails     = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic rs_data m_wake(rs_data d, bit v, logic [PTAG_W-1:0] t);
    if (v && d.src1_tag == t) d.src1_rdy = 1'b1;
    if (v && d.src2_tag == t) d.src2_rdy = 1'b1;
    return d;
  endfunction

  function automatic int m_pick();
    if (m_lock_id >= 0)
      foreach (mq[k]) if (mq[k].id == m_lock_id) return k;
    foreach (mq[k]) if (mq[k].d.src1_rdy && mq[k].d.src2_rdy) return k;
    return -1;
  endfunction

  task automatic compare();
    int  k;
    bit  exp_iv;
    k      = m_pick();
    exp_iv = !flush && (k >= 0);
    chk("issue_valid", 64'(bus.issue_valid), 64'(exp_iv));
    if (exp_iv) chk("issue_entry", 64'(bus.issue_entry), 64'(mq[k].d));
    chk("disp_ready", 64'(bus.disp_ready), 64'((8 - mq.size()) >= 2));
    chk("free_count", 64'(bus.free_count), 64'(8 - mq.size()));
`ifdef RS_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  task automatic model_step();
    int k;
    int new_lock;
    bit dr;
    if (reset) begin
      mq.delete();
      m_lock_id = -1;
      m_stall   = 0;
      m_known   = 1;
      return;
    end
    if (!m_known) return;
    dr = (8 - mq.size()) >= 2;
    if ((|bus.disp_valid) && !dr && m_stall != 65535) m_stall++;
    if (flush) begin
      mq.delete();
      m_lock_id = -1;
      return;
    end
    k        = m_pick();
    new_lock = (k >= 0 && !bus.issue_ready) ? mq[k].id : -1;
    if (k >= 0 && bus.issue_ready) mq.delete(k);
    foreach (mq[j]) mq[j].d = m_wake(mq[j].d, bus.cdb_valid, bus.cdb_tag);
    if (dr) begin
      for (int l = 0; l < 2; l++) begin
        if (bus.disp_valid[l]) begin
          mq.push_back('{d: m_wake(bus.disp_entry[l], bus.cdb_valid, bus.cdb_tag),
                         id: m_next_id});
          m_next_id++;
        end
      end
    end
    m_lock_id = new_lock;
  endtask

  // Checks just after inputs settle, then advances the model on the edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (m_known) compare();
      @(posedge clk);
      model_step();
    end
  end

  function automatic rs_data mk(logic [7:0] op, logic [PTAG_W-1:0] t1, bit r1,
                                logic [PTAG_W-1:0] t2, bit r2);
    rs_data d;
    d.op       = op;
    d.dst_tag  = op[PTAG_W-1:0];
    d.src1_tag = t1;
    d.src1_rdy = r1;
    d.src2_tag = t2;
    d.src2_rdy = r2;
    return d;
  endfunction

  task automatic drive(bit rst, bit fl, logic [1:0] dv, rs_data e0, rs_data e1,
                       bit cv, logic [PTAG_W-1:0] tag, bit ir);
    @(negedge clk);
    reset              = rst;
    flush              = fl;
    bus.disp_valid     = dv;
    bus.disp_entry[0]  = e0;
    bus.disp_entry[1]  = e1;
    bus.cdb_valid      = cv;
    bus.cdb_tag        = tag;
    bus.issue_ready    = ir;
  endtask

  task automatic idle(bit ir);
    drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0, '0, ir);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 2'b00, '0, '0, 1'b0, '0, 1'b0);
    idle(1'b0);
  endtask

  rs_data a, b, e [4], x, y;

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus.disp_valid    = '0;
    bus.disp_entry[0] = '0;
    bus.disp_entry[1] = '0;
    bus.cdb_valid     = 1'b0;
    bus.cdb_tag       = '0;
    bus.issue_ready   = 1'b0;

    // Reset state, then two ready entries become issuable next cycle.
    do_reset();
    #3;
    chk("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
    chk("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
    chk("rst_free_count", 64'(bus.free_count), 64'd8);
    a = mk(8'h11, 6'd1, 1'b1, 6'd2, 1'b1);
    b = mk(8'h22, 6'd3, 1'b1, 6'd4, 1'b1);
    drive(1'b0, 1'b0, 2'b11, a, b, 1'b0, '0, 1'b0);
    idle(1'b0);
    #3;
    chk("s1_issue_valid", 64'(bus.issue_valid), 64'd1);
    chk("s1_issue_entry", 64'(bus.issue_entry), 64'(a));
    chk("s1_free_count", 64'(bus.free_count), 64'd6);

    // Four entries wait on tag 5; one broadcast wakes all, issue oldest first.
    do_reset();
    for (int i = 0; i < 4; i++) e[i] = mk(8'(8'h30 + i), 6'd5, 1'b0, 6'd1, 1'b1);
    drive(1'b0, 1'b0, 2'b11, e[0], e[1], 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 2'b11, e[2], e[3], 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b1, 6'd5, 1'b0);
    #3;
    chk("s2_not_yet_valid", 64'(bus.issue_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      #3;
      chk("s2_issue_valid", 64'(bus.issue_valid), 64'd1);
      chk("s2_issue_order", 64'(bus.issue_entry), 64'(mk(8'(8'h30 + i), 6'd5, 1'b1, 6'd1, 1'b1)));
    end
    idle(1'b0);
    #3;
    chk("s2_drained", 64'(bus.free_count), 64'd8);

    // Fill to seven; further dispatch is held off.
    do_reset();
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b0, 2'b11, mk(8'h50, 6'd7, 1'b0, 6'd1, 1'b1),
            mk(8'h51, 6'd7, 1'b0, 6'd1, 1'b1), 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 2'b01, mk(8'h52, 6'd7, 1'b0, 6'd1, 1'b1), '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 2'b11, mk(8'h60, 6'd1, 1'b1, 6'd1, 1'b1),
            mk(8'h61, 6'd1, 1'b1, 6'd1, 1'b1), 1'b0, '0, 1'b0);
      #3;
      chk("s3_disp_ready", 64'(bus.disp_ready), 64'd0);
      chk("s3_free_count", 64'(bus.free_count), 64'd1);
    end
    idle(1'b0);
    #3;
    chk("s3_table_unchanged", 64'(bus.free_count), 64'd1);
    chk("s3_none_ready", 64'(bus.issue_valid), 64'd0);
`ifdef RS_STALL_CNT_EN
    chk("s3_stall_cnt", 64'(stall_cnt), 64'd3);
`endif

    // Dispatch while its source tag is broadcast: issues without another broadcast.
    do_reset();
    drive(1'b0, 1'b0, 2'b01, mk(8'h44, 6'd9, 1'b0, 6'd3, 1'b1), '0, 1'b1, 6'd9, 1'b0);
    #3;
    chk("s4_same_cycle", 64'(bus.issue_valid), 64'd0);
    idle(1'b0);
    #3;
    chk("s4_issue_valid", 64'(bus.issue_valid), 64'd1);
    chk("s4_issue_entry", 64'(bus.issue_entry), 64'(mk(8'h44, 6'd9, 1'b1, 6'd3, 1'b1)));

    // Stalled FU: selection holds while a younger entry wakes.
    do_reset();
    x = mk(8'h70, 6'd1, 1'b1, 6'd2, 1'b1);
    y = mk(8'h71, 6'd3, 1'b0, 6'd2, 1'b1);
    drive(1'b0, 1'b0, 2'b11, x, y, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 2'b00, '0, '0, (i == 0), 6'd3, 1'b0);
      #3;
      chk("s5_hold_entry", 64'(bus.issue_entry), 64'(x));
    end
    idle(1'b1);
    #3;
    chk("s5_accept_x", 64'(bus.issue_entry), 64'(x));
    idle(1'b1);
    #3;
    chk("s5_then_y", 64'(bus.issue_entry), 64'(mk(8'h71, 6'd3, 1'b1, 6'd2, 1'b1)));

    // Flush beats dispatch and issue.
    do_reset();
    drive(1'b0, 1'b0, 2'b11, a, b, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 2'b11, a, b, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 2'b01, a, b, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b1, 2'b11, a, b, 1'b1, 6'd1, 1'b1);
    #3;
    chk("s6_flush_no_issue", 64'(bus.issue_valid), 64'd0);
    idle(1'b1);
    #3;
    chk("s6_free_count", 64'(bus.free_count), 64'd8);
    chk("s6_issue_valid", 64'(bus.issue_valid), 64'd0);

    // Random traffic with small tag space so wakeups are frequent.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 255) == 0), ($urandom_range(0, 63) == 0),
            2'($urandom_range(0, 3)),
            mk(8'($urandom), 6'($urandom_range(0, 7)), 1'($urandom),
               6'($urandom_range(0, 7)), 1'($urandom)),
            mk(8'($urandom), 6'($urandom_range(0, 7)), 1'($urandom),
               6'($urandom_range(0, 7)), 1'($urandom)),
            ($urandom_range(0, 9) < 4), 6'($urandom_range(0, 7)),
            ($urandom_range(0, 9) < 6));
    end
    idle(1'b0);
    idle(1'b0);
    @(negedge clk);
    #4;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
